// File: rtl/logic_test_unit.sv
// Two-stage flag-setting logical test unit (TST/TEQ/ORT/BCT) with valid/ready handshake.
// Optional B-operand left shifter with carry-out is enabled by defining LTU_SHIFTER_EN.
module logic_test_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    input  logic             flush,
    input  logic             flags_wr,
    input  logic [1:0]       flags_in,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [1:0] {
        OP_TST = 2'b00,
        OP_TEQ = 2'b01,
        OP_ORT = 2'b10,
        OP_BCT = 2'b11
    } op_e;

    function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input op_e op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_TST:  r = a & b;
            OP_TEQ:  r = a ^ b;
            OP_ORT:  r = a | b;
            OP_BCT:  r = a & ~b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_e              op_q, op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic             s2_load_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] op_result_s;
    logic             sh_carry_en_s;
    logic             sh_carry_s;

    assign s2_load_s   = s1_valid_q && (!s2_valid_q || out_ready) && !flush;
    assign in_ready_s  = !flush && (!s1_valid_q || s2_load_s);
    assign accept_s    = in_valid && in_ready_s;
    assign op_result_s = logic_op(a_q, b_eff_s, op_q);

`ifdef LTU_SHIFTER_EN
    logic [SHW-1:0] shamt_q, shamt_d;
    logic [WIDTH:0] b_wide_s;

    // Shift amount travels with its beat through S1
    always_comb begin
        if (accept_s) begin
            shamt_d = in_shamt;
        end else begin
            shamt_d = shamt_q;
        end
    end

    // Shift amount register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shamt_q <= {SHW{1'b0}};
        end else begin
            shamt_q <= shamt_d;
        end
    end

    // The extra top bit catches the last bit shifted out of B
    assign b_wide_s      = {1'b0, b_q} << shamt_q;
    assign b_eff_s       = b_wide_s[WIDTH-1:0];
    assign sh_carry_en_s = (shamt_q != {SHW{1'b0}});
    assign sh_carry_s    = b_wide_s[WIDTH];
`else
    logic unused_shamt_s;
    assign unused_shamt_s = ^in_shamt;
    assign b_eff_s        = b_q;
    assign sh_carry_en_s  = 1'b0;
    assign sh_carry_s     = 1'b0;
`endif

    // Pipeline advance, result capture and flag update
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        n_d        = n_q;
        z_d        = z_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_d = 1'b1;
                a_d        = in_a;
                b_d        = in_b;
                op_d       = op_e'(in_op);
            end else if (s2_load_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (s2_load_s) begin
                s2_valid_d = 1'b1;
                result_d   = op_result_s;
                n_d        = op_result_s[WIDTH-1];
                z_d        = (op_result_s == {WIDTH{1'b0}});
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end else begin
                s2_valid_d = s2_valid_q;
            end
        end
        // A shifter carry on the same edge overrides an explicit C load
        if (s2_load_s && sh_carry_en_s) begin
            c_d = sh_carry_s;
        end else if (flags_wr) begin
            c_d = flags_in[1];
        end else begin
            c_d = c_q;
        end
        if (flags_wr) begin
            v_d = flags_in[0];
        end else begin
            v_d = v_q;
        end
    end

    // Pipeline and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            op_q       <= OP_TST;
            s2_valid_q <= 1'b0;
            result_q   <= {WIDTH{1'b0}};
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            n_q        <= n_d;
            z_q        <= z_d;
            c_q        <= c_d;
            v_q        <= v_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign flag_n     = n_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign flag_v     = v_q;

endmodule
